// File: rtl/genius_pkg.sv
// Shared definitions for the GENIUS memory game: state encoding and default
// timing constants, used by the control unit and by the datapath bench.
package genius_pkg;

    localparam int STATE_W         = 3;
    localparam int CHECK_DELAY_DEF = 2;

    typedef enum logic [STATE_W-1:0] {
        S_INIT   = 3'd0,
        S_SETUP  = 3'd1,
        S_PREP   = 3'd2,
        S_SEQ    = 3'd3,
        S_PLAY   = 3'd4,
        S_CHECK  = 3'd5,
        S_NEXT   = 3'd6,
        S_RESULT = 3'd7
    } state_t;

endpackage

// File: rtl/key_edge_sync.sv
// Synchronises the raw active-low enter key and emits a one-cycle pulse on the
// press (1 -> 0) edge.
module key_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_press
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    // Every flop resets to "pressed", so a key held through reset release
    // has to be released and pressed again before a pulse appears.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_key_n};
            r_hist <= w_synced;
        end
    end

    assign o_press = r_hist & ~w_synced;

endmodule

// File: rtl/game_control_fsm.sv
// Control unit for the GENIUS game: Moore FSM that sequences setup, FPGA
// playback, user entry, check and result, driving the datapath controls.
module game_control_fsm
    import genius_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CHECK_DELAY = CHECK_DELAY_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               enter_n,
    input  logic               end_FPGA,
    input  logic               end_User,
    input  logic               end_time,
    input  logic               win,
    input  logic               match,
    output logic               R1,
    output logic               R2,
    output logic               E1,
    output logic               E2,
    output logic               E3,
    output logic               E4,
    output logic               SEL,
    output logic [STATE_W-1:0] state_o
);

    localparam int              CNT_W    = (CHECK_DELAY > 1) ? $clog2(CHECK_DELAY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CHECK_DELAY - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_chkCnt;
    logic             w_enterPulse;

    key_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_keySync (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset),
        .i_key_n (enter_n),
        .o_press (w_enterPulse)
    );

    // The check counter is loaded on the PLAY -> CHECK transition so the
    // match/win flags are sampled exactly CHECK_DELAY cycles after entry.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state  <= S_INIT;
            r_chkCnt <= '0;
        end else begin
            case (r_state)
                S_INIT:   r_state <= S_SETUP;
                S_SETUP:  if (w_enterPulse) r_state <= S_PREP;
                S_PREP:   r_state <= S_SEQ;
                S_SEQ:    if (end_FPGA) r_state <= S_PLAY;
                S_PLAY: begin
                    if (end_User) begin
                        r_state  <= S_CHECK;
                        r_chkCnt <= CNT_LOAD;
                    end else if (end_time) begin
                        r_state <= S_RESULT;
                    end
                end
                S_CHECK: begin
                    if (r_chkCnt == '0) begin
                        r_state <= (match && !win) ? S_NEXT : S_RESULT;
                    end else begin
                        r_chkCnt <= r_chkCnt - CNT_W'(1);
                    end
                end
                S_NEXT:   r_state <= S_PREP;
                S_RESULT: if (w_enterPulse) r_state <= S_INIT;
                default:  r_state <= S_INIT;
            endcase
        end
    end

    // Outputs decode from the state register alone, so an asserted reset
    // drives R1/R2 to the datapath without waiting for a clock edge.
    always_comb begin
        R1  = 1'b0;
        R2  = 1'b0;
        E1  = 1'b0;
        E2  = 1'b0;
        E3  = 1'b0;
        E4  = 1'b0;
        SEL = 1'b0;
        case (r_state)
            S_INIT: begin
                R1 = 1'b1;
                R2 = 1'b1;
            end
            S_SETUP:  E1  = 1'b1;
            S_PREP:   R2  = 1'b1;
            S_SEQ:    E3  = 1'b1;
            S_PLAY:   E2  = 1'b1;
            S_NEXT:   E4  = 1'b1;
            S_RESULT: SEL = 1'b1;
            default: ;
        endcase
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_game_control_fsm.sv
// Directed bench for game_control_fsm with SYNC_STAGES=2 and CHECK_DELAY=2.
module tb_game_control_fsm;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b0;
    logic       enter_n  = 1'b1;
    logic       end_FPGA = 1'b0;
    logic       end_User = 1'b0;
    logic       end_time = 1'b0;
    logic       win      = 1'b0;
    logic       match    = 1'b0;
    logic       R1, R2, E1, E2, E3, E4, SEL;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;

    // Observed vector: {state_o, R1, R2, E1, E2, E3, E4, SEL}
    logic [9:0] obs;
    assign obs = {state_o, R1, R2, E1, E2, E3, E4, SEL};

    localparam logic [9:0] X_INIT   = {3'd0, 7'b1100000};
    localparam logic [9:0] X_SETUP  = {3'd1, 7'b0010000};
    localparam logic [9:0] X_PREP   = {3'd2, 7'b0100000};
    localparam logic [9:0] X_SEQ    = {3'd3, 7'b0000100};
    localparam logic [9:0] X_PLAY   = {3'd4, 7'b0001000};
    localparam logic [9:0] X_CHECK  = {3'd5, 7'b0000000};
    localparam logic [9:0] X_NEXT   = {3'd6, 7'b0000010};
    localparam logic [9:0] X_RESULT = {3'd7, 7'b0000001};

    game_control_fsm #(
        .SYNC_STAGES(2),
        .CHECK_DELAY(2)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .enter_n  (enter_n),
        .end_FPGA (end_FPGA),
        .end_User (end_User),
        .end_time (end_time),
        .win      (win),
        .match    (match),
        .R1       (R1),
        .R2       (R2),
        .E1       (E1),
        .E2       (E2),
        .E3       (E3),
        .E4       (E4),
        .SEL      (SEL),
        .state_o  (state_o)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Advance n rising edges; inputs are driven and outputs sampled at negedges.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge CLOCK_50);
    endtask

    task automatic test_reset;
        reset   = 1'b0;
        enter_n = 1'b1;
        cycles(3);
        total++;
        if (obs !== X_INIT) begin bad++; $display("[TB] FAIL reset_hold obs=%b exp=%b", obs, X_INIT); end
        reset = 1'b1;
        #1;
        total++;
        if (obs !== X_INIT) begin bad++; $display("[TB] FAIL reset_first obs=%b exp=%b", obs, X_INIT); end
        cycles(1);
        total++;
        if (obs !== X_SETUP) begin bad++; $display("[TB] FAIL reset_setup obs=%b exp=%b", obs, X_SETUP); end
        cycles(4);
        total++;
        if (obs !== X_SETUP) begin bad++; $display("[TB] FAIL setup_idle obs=%b exp=%b", obs, X_SETUP); end
    endtask

    // Enter press in SETUP, FPGA playback, then a correct non-final round.
    task automatic test_round;
        enter_n = 1'b0;
        cycles(2);
        total++;
        if (obs !== X_SETUP) begin bad++; $display("[TB] FAIL press_latency obs=%b exp=%b", obs, X_SETUP); end
        cycles(1);
        total++;
        if (obs !== X_PREP) begin bad++; $display("[TB] FAIL press_prep obs=%b exp=%b", obs, X_PREP); end
        cycles(1);
        total++;
        if (obs !== X_SEQ) begin bad++; $display("[TB] FAIL prep_one_cycle obs=%b exp=%b", obs, X_SEQ); end
        enter_n = 1'b1;
        cycles(3);
        total++;
        if (obs !== X_SEQ) begin bad++; $display("[TB] FAIL seq_hold obs=%b exp=%b", obs, X_SEQ); end
        end_FPGA = 1'b1;
        cycles(1);
        end_FPGA = 1'b0;
        total++;
        if (obs !== X_PLAY) begin bad++; $display("[TB] FAIL seq_to_play obs=%b exp=%b", obs, X_PLAY); end
        cycles(2);
        total++;
        if (obs !== X_PLAY) begin bad++; $display("[TB] FAIL play_hold obs=%b exp=%b", obs, X_PLAY); end
        end_User = 1'b1;
        match    = 1'b1;
        win      = 1'b0;
        cycles(1);
        total++;
        if (obs !== X_CHECK) begin bad++; $display("[TB] FAIL check_1 obs=%b exp=%b", obs, X_CHECK); end
        cycles(1);
        total++;
        if (obs !== X_CHECK) begin bad++; $display("[TB] FAIL check_2 obs=%b exp=%b", obs, X_CHECK); end
        cycles(1);
        total++;
        if (obs !== X_NEXT) begin bad++; $display("[TB] FAIL check_to_next obs=%b exp=%b", obs, X_NEXT); end
        end_User = 1'b0;
        match    = 1'b0;
        cycles(1);
        total++;
        if (obs !== X_PREP) begin bad++; $display("[TB] FAIL next_to_prep obs=%b exp=%b", obs, X_PREP); end
        cycles(1);
        total++;
        if (obs !== X_SEQ) begin bad++; $display("[TB] FAIL round2_seq obs=%b exp=%b", obs, X_SEQ); end
    endtask

    // Wrong entry ends in RESULT, which holds until a fresh enter press.
    task automatic test_lose;
        end_FPGA = 1'b1;
        cycles(1);
        end_FPGA = 1'b0;
        total++;
        if (obs !== X_PLAY) begin bad++; $display("[TB] FAIL lose_play obs=%b exp=%b", obs, X_PLAY); end
        end_User = 1'b1;
        match    = 1'b0;
        win      = 1'b1;
        cycles(3);
        total++;
        if (obs !== X_RESULT) begin bad++; $display("[TB] FAIL mismatch_result obs=%b exp=%b", obs, X_RESULT); end
        end_User = 1'b0;
        win      = 1'b0;
        cycles(6);
        total++;
        if (obs !== X_RESULT) begin bad++; $display("[TB] FAIL result_hold obs=%b exp=%b", obs, X_RESULT); end
        enter_n = 1'b0;
        cycles(2);
        total++;
        if (obs !== X_RESULT) begin bad++; $display("[TB] FAIL result_latency obs=%b exp=%b", obs, X_RESULT); end
        cycles(1);
        total++;
        if (obs !== X_INIT) begin bad++; $display("[TB] FAIL result_to_init obs=%b exp=%b", obs, X_INIT); end
        cycles(1);
        total++;
        if (obs !== X_SETUP) begin bad++; $display("[TB] FAIL init_to_setup obs=%b exp=%b", obs, X_SETUP); end
        enter_n = 1'b1;
        cycles(4);
        total++;
        if (obs !== X_SETUP) begin bad++; $display("[TB] FAIL no_retrigger obs=%b exp=%b", obs, X_SETUP); end
    endtask

    // From SETUP: press, playback, enter ignored in PLAY, end_User beats end_time.
    task automatic test_priority;
        enter_n = 1'b0;
        cycles(3);
        enter_n = 1'b1;
        cycles(1);
        end_FPGA = 1'b1;
        cycles(1);
        end_FPGA = 1'b0;
        total++;
        if (obs !== X_PLAY) begin bad++; $display("[TB] FAIL prio_play obs=%b exp=%b", obs, X_PLAY); end
        cycles(3);
        enter_n = 1'b0;
        cycles(4);
        total++;
        if (obs !== X_PLAY) begin bad++; $display("[TB] FAIL enter_ignored obs=%b exp=%b", obs, X_PLAY); end
        enter_n  = 1'b1;
        cycles(3);
        end_time = 1'b1;
        end_User = 1'b1;
        match    = 1'b1;
        win      = 1'b1;
        cycles(1);
        end_time = 1'b0;
        end_User = 1'b0;
        total++;
        if (obs !== X_CHECK) begin bad++; $display("[TB] FAIL user_over_time obs=%b exp=%b", obs, X_CHECK); end
        cycles(2);
        total++;
        if (obs !== X_RESULT) begin bad++; $display("[TB] FAIL win_result obs=%b exp=%b", obs, X_RESULT); end
        match   = 1'b0;
        win     = 1'b0;
        enter_n = 1'b0;
        cycles(4);
        total++;
        if (obs !== X_SETUP) begin bad++; $display("[TB] FAIL win_restart obs=%b exp=%b", obs, X_SETUP); end
        enter_n = 1'b1;
        cycles(3);
        enter_n = 1'b0;
        cycles(4);
        enter_n = 1'b1;
        end_FPGA = 1'b1;
        cycles(1);
        end_FPGA = 1'b0;
        total++;
        if (obs !== X_PLAY) begin bad++; $display("[TB] FAIL timeout_play obs=%b exp=%b", obs, X_PLAY); end
        end_time = 1'b1;
        cycles(1);
        end_time = 1'b0;
        total++;
        if (obs !== X_RESULT) begin bad++; $display("[TB] FAIL timeout_result obs=%b exp=%b", obs, X_RESULT); end
    endtask

    // Key held through reset release, then an asynchronous abort during SEQ.
    task automatic test_held_key_abort;
        reset   = 1'b0;
        enter_n = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(6);
        total++;
        if (obs !== X_SETUP) begin bad++; $display("[TB] FAIL held_key_stays obs=%b exp=%b", obs, X_SETUP); end
        enter_n = 1'b1;
        cycles(4);
        total++;
        if (obs !== X_SETUP) begin bad++; $display("[TB] FAIL release_no_pulse obs=%b exp=%b", obs, X_SETUP); end
        enter_n = 1'b0;
        cycles(3);
        total++;
        if (obs !== X_PREP) begin bad++; $display("[TB] FAIL repress_prep obs=%b exp=%b", obs, X_PREP); end
        enter_n = 1'b1;
        cycles(2);
        total++;
        if (obs !== X_SEQ) begin bad++; $display("[TB] FAIL abort_pre_seq obs=%b exp=%b", obs, X_SEQ); end
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (obs !== X_INIT) begin bad++; $display("[TB] FAIL abort_immediate obs=%b exp=%b", obs, X_INIT); end
        cycles(2);
        reset = 1'b1;
        cycles(1);
        total++;
        if (obs !== X_SETUP) begin bad++; $display("[TB] FAIL abort_recover obs=%b exp=%b", obs, X_SETUP); end
    endtask

    initial begin
        test_reset();
        test_round();
        test_lose();
        test_priority();
        test_held_key_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
